// File: rtl/sample_pack.sv
// Purpose: packs RATIO consecutive IN_W-bit samples into one IN_W*RATIO-bit word.
// Latency: the word appears 1 cycle after its last sample is accepted.
// Backpressure: the input never stalls; a word that completes while the previous one is still held is dropped and sets sticky overflow.
//
// Ports:
//   clk, resetn          rising-edge clock; asynchronous active-low reset
//   in_data/in_valid     one sample accepted per cycle with in_valid=1
//   in_sync              frame marker, the sample on this cycle goes to slot 0
//   out_data/out_valid   packed word; out_ready completes the handshake
//   overflow / ovf_clr   sticky drop flag; synchronous clear (a same-cycle drop wins)
//   ovf_count            16-bit saturating drop count, only present with SAMPLE_PACK_OVF_CNT_EN
//
// Optional feature macro: SAMPLE_PACK_OVF_CNT_EN
module sample_pack #(
  parameter int IN_W      = 16,
  parameter int RATIO     = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  input  logic                  in_sync,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  input  logic                  ovf_clr
`ifdef SAMPLE_PACK_OVF_CNT_EN
  ,
  output logic [15:0]           ovf_count
`endif
);

  localparam int W     = IN_W * RATIO;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] slot_q;
  logic [CNT_W-1:0] slot;
  logic [CNT_W-1:0] slot_d;
  logic [W-1:0]     asm_q;
  logic [W-1:0]     asm_next;
  logic             complete;
  logic             load;
  logic             drop;

  // in_sync forces the current sample into slot 0. This restarts the frame,
  // so the partial word is discarded without clearing the register.
  always_comb begin
    slot = in_sync ? '0 : slot_q;
  end

  assign complete = in_valid && (slot == LAST_SLOT);
  assign load     = complete && (!out_valid || out_ready);
  assign drop     = complete && out_valid && !out_ready;

  always_comb begin
    slot_d = slot_q;
    if (in_valid) begin
      if (complete) begin
        slot_d = '0;
      end else begin
        slot_d = slot + CNT_W'(1);
      end
    end
  end

  // The slot-to-field mapping is fixed at elaboration time. The completed word
  // is taken from asm_next, so the last sample is captured without extra delay.
  always_comb begin
    asm_next = asm_q;
    if (in_valid) begin
      for (int i = 0; i < RATIO; i++) begin
        if (slot == CNT_W'(i)) begin
          asm_next[((LSB_FIRST != 0) ? i : (RATIO - 1 - i)) * IN_W +: IN_W] = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q <= '0;
      asm_q  <= '0;
    end else begin
      slot_q <= slot_d;
      asm_q  <= asm_next;
    end
  end

  // Output holding register. A completion during a handshake replaces the
  // word and keeps out_valid high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= asm_next;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef SAMPLE_PACK_OVF_CNT_EN
  // If a clear and a drop happen together, the count restarts at 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_count <= '0;
    end else if (drop) begin
      if (ovf_clr) begin
        ovf_count <= 16'd1;
      end else if (ovf_count != 16'hFFFF) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end
  end
`endif

endmodule

// File: doc/sample_pack.md
SAMPLE_PACK -- requirements
Module: sample_pack

Interface
REQ-001 SHALL have parameter IN_W, default 16, input sample width in bits (legal 8..32).
REQ-002 SHALL have parameter RATIO, default 2, samples packed per output word (legal 2..8).
REQ-003 SHALL have parameter LSB_FIRST, default 1; 1 = first sample in bits [IN_W-1:0], 0 = first sample in the most significant slot.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  IN_W  sample.
REQ-007 SHALL have port in_valid  input  1  sample qualifier; one sample accepted per cycle with in_valid=1 (no backpressure).
REQ-008 SHALL have port in_sync  input  1  frame marker; sample on this cycle is slot 0.
REQ-009 SHALL have port out_data  output  IN_W*RATIO  packed word.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts word when out_valid=1 and out_ready=1.
REQ-012 SHALL have port overflow  output  1  sticky flag, a completed word was dropped.
REQ-013 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL keep a slot counter 0..RATIO-1; each accepted sample is written to the assembly register at the current slot and the counter advances, wrapping RATIO-1 -> 0.
REQ-015 SHALL, when in_sync=1 and in_valid=1, write the sample to slot 0, discard any partial word, and set the counter to 1 (to 0 if RATIO=1 is ever legalised).
REQ-016 SHALL ignore in_sync when in_valid=0, counter unchanged.
REQ-017 SHALL treat a word as complete on the cycle the slot RATIO-1 sample is accepted; out_data/out_valid update on the next rising edge (latency 1 cycle after last sample).
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear out_valid after a handshake unless a new word completes the same cycle.
REQ-020 SHALL, when a word completes while out_valid=1 and out_ready=0, drop the new word, keep the held word, and set overflow on the next edge.
REQ-021 SHALL, when a word completes in the same cycle as a handshake, load the new word with out_valid staying 1 and no overflow.
REQ-022 SHALL give a same-cycle overflow set precedence over ovf_clr.
REQ-023 SHALL leave unwritten slots of the assembly register with their previous contents; only complete words reach out_data.
REQ-024 SHALL apply LSB_FIRST as a static slot-to-bit-field mapping with no cycle cost.

Reset
REQ-025 SHALL on resetn=0 immediately set slot counter 0, assembly register 0, out_data 0, out_valid 0, overflow 0 (and ovf_count 0 when present).
REQ-026 SHALL discard any partial word on reset mid-frame; first sample after release is slot 0.

Configuration
REQ-027 SHALL, with macro SAMPLE_PACK_OVF_CNT_EN defined, add port ovf_count  output  16  count of dropped words, saturating at 16'hFFFF, cleared by ovf_clr unless a drop occurs the same cycle (then set to 1).
REQ-028 SHALL, without SAMPLE_PACK_OVF_CNT_EN, omit ovf_count and its logic; all other behaviour identical.

Verification
REQ-029 SHALL cover defaults, out_ready=1, in_valid=1 samples 0x1111,0x2222,0x3333,0x4444 -> out_data 0x22221111 then 0x44443333, out_valid pulses 1 cycle after each second sample.
REQ-030 SHALL cover RATIO=4, LSB_FIRST=0, samples 0xA,0xB,0xC,0xD (IN_W=16) -> out_data 0x000A000B000C000D.
REQ-031 SHALL cover in_sync with the 2nd sample of a RATIO=4 frame -> partial discarded, next word formed from that sample plus the following 3.
REQ-032 SHALL cover out_ready=0 across 2 completed words -> first word held unchanged, overflow=1, ovf_count=1 (macro on); ovf_clr -> both 0.
REQ-033 SHALL cover completion coincident with handshake -> out_valid stays 1, new word presented, overflow stays 0.
REQ-034 SHALL cover resetn pulsed low after 1 of 2 samples -> all outputs 0 asynchronously; next two samples form a clean word.
